// File: rtl/mips_timer.sv
// Memory-mapped 32-bit down-counting timer with maskable interrupt request.
// Define MIPS_TIMER_RELOAD_EN to build in the auto-reload (MODE 1) support.
module mips_timer #(
    parameter logic BASE_SEL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic        wr_ctrl;
    logic        wr_preset;
    logic        reload;
    logic [1:0]  mode_wr;

    assign wr_ctrl   = (sel == BASE_SEL) && we && (addr == 2'd0);
    assign wr_preset = (sel == BASE_SEL) && we && (addr == 2'd1);

`ifdef MIPS_TIMER_RELOAD_EN
    // MODE values 2 and 3 behave as one-shot.
    assign reload  = (mode_q == 2'd1);
    assign mode_wr = wdata[2:1];
`else
    assign reload  = 1'b0;
    assign mode_wr = 2'd0;
`endif

    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        mode_d     = mode_q;
        im_d       = im_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            S_IDLE: begin
                if (en_q) state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // COUNT of 1 or 0 both expire here; 0 never decrements.
                    count_d    = 32'd0;
                    irq_flag_d = 1'b1;
                    state_d    = S_INT;
                end
            end
            S_INT: begin
                state_d = S_IDLE;
                if (reload) irq_flag_d = 1'b0;
                else        en_d       = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // Bus writes come last so they override FSM updates on the same edge.
        if (wr_ctrl) begin
            en_d       = wdata[0];
            mode_d     = mode_wr;
            im_d       = wdata[3];
            irq_flag_d = 1'b0;
        end
        if (wr_preset) begin
            preset_d   = wdata;
            irq_flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            mode_q     <= 2'd0;
            im_q       <= 1'b0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            im_q       <= im_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (sel == BASE_SEL) begin
            case (addr)
                2'd0:    rdata = {28'd0, im_q, mode_q, en_q};
                2'd1:    rdata = preset_q;
                2'd2:    rdata = count_q;
                default: rdata = 32'd0;
            endcase
        end
    end

    assign irq = irq_flag_q & im_q;

endmodule

// File: tb/tb_mips_timer.sv
// Testbench for mips_timer: vector table, hand-written corner sequences and
// randomized traffic against a behavioural model.
module tb_mips_timer;

    localparam logic BASE_SEL = 1'b1;
`ifdef MIPS_TIMER_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    mips_timer #(.BASE_SEL(BASE_SEL)) dut (
        .clk   (clk),
        .reset (rst_n),
        .sel   (sel),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: phase 0 idle, 1 load, 2 counting, 3 expired.
    int          m_phase = 0;
    longint      m_left  = 0;
    logic        m_en    = 1'b0;
    logic [1:0]  m_mode  = 2'd0;
    logic        m_im    = 1'b0;
    logic [31:0] m_preset = 32'd0;
    logic [31:0] m_count  = 32'd0;
    logic        m_flag   = 1'b0;

    task automatic model_edge(input logic rn, input logic s, input logic w,
                              input logic [1:0] a, input logic [31:0] d);
        logic wr;
        wr = (s == BASE_SEL) && w;
        if (!rn) begin
            m_phase = 0; m_left = 0; m_en = 1'b0; m_mode = 2'd0; m_im = 1'b0;
            m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0;
        end else begin
            case (m_phase)
                0: if (m_en) m_phase = 1;
                1: begin
                    m_count = m_preset;
                    m_left  = (m_preset == 32'd0) ? 64'd1 : {32'd0, m_preset};
                    m_phase = 2;
                end
                2: begin
                    if (!m_en) begin
                        m_phase = 0;
                    end else begin
                        if (m_count != 32'd0) m_count = m_count - 32'd1;
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            m_flag  = 1'b1;
                            m_phase = 3;
                        end
                    end
                end
                default: begin
                    m_phase = 0;
                    if (RELOAD && m_mode == 2'd1) m_flag = 1'b0;
                    else                          m_en   = 1'b0;
                end
            endcase
            if (wr && a == 2'd0) begin
                m_en   = d[0];
                m_mode = RELOAD ? d[2:1] : 2'd0;
                m_im   = d[3];
                m_flag = 1'b0;
            end
            if (wr && a == 2'd1) begin
                m_preset = d;
                m_flag   = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] model_read(input logic s, input logic [1:0] a);
        if (s != BASE_SEL) return 32'd0;
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic rn, input logic s, input logic w,
                        input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        rst_n = rn; sel = s; we = w; addr = a; wdata = d;
        @(posedge clk);
        model_edge(rn, s, w, a, d);
        #1;
        check("model_irq", {31'd0, irq}, {31'd0, m_flag & m_im});
        check("model_rdata", rdata, model_read(s, a));
    endtask

    typedef struct {
        logic        s;
        logic        w;
        logic [1:0]  a;
        logic [31:0] d;
        logic        e_irq;
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl[30];

    task automatic set_vec(input int i, input logic s, input logic w, input logic [1:0] a,
                           input logic [31:0] d, input logic ei, input logic [31:0] er);
        tbl[i].s = s; tbl[i].w = w; tbl[i].a = a; tbl[i].d = d;
        tbl[i].e_irq = ei; tbl[i].e_rd = er;
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;

        // One-shot P=5 with IM, then PRESET=0, masked run, bus corner cases.
        set_vec(0,  1, 1, 2'd1, 32'd5,  0, 32'd5);
        set_vec(1,  1, 1, 2'd0, 32'h9,  0, 32'h9);
        set_vec(2,  1, 0, 2'd2, 32'd0,  0, 32'd0);
        set_vec(3,  1, 0, 2'd2, 32'd0,  0, 32'd5);
        set_vec(4,  1, 0, 2'd2, 32'd0,  0, 32'd4);
        set_vec(5,  1, 0, 2'd2, 32'd0,  0, 32'd3);
        set_vec(6,  1, 0, 2'd2, 32'd0,  0, 32'd2);
        set_vec(7,  1, 0, 2'd2, 32'd0,  0, 32'd1);
        set_vec(8,  1, 0, 2'd2, 32'd0,  1, 32'd0);
        set_vec(9,  1, 0, 2'd0, 32'd0,  1, 32'h8);
        set_vec(10, 1, 0, 2'd0, 32'd0,  1, 32'h8);
        set_vec(11, 1, 1, 2'd1, 32'd5,  0, 32'd5);
        set_vec(12, 1, 0, 2'd2, 32'd0,  0, 32'd0);
        set_vec(13, 1, 1, 2'd1, 32'd0,  0, 32'd0);
        set_vec(14, 1, 1, 2'd0, 32'h9,  0, 32'h9);
        set_vec(15, 1, 0, 2'd2, 32'd0,  0, 32'd0);
        set_vec(16, 1, 0, 2'd2, 32'd0,  0, 32'd0);
        set_vec(17, 1, 0, 2'd2, 32'd0,  1, 32'd0);
        set_vec(18, 1, 0, 2'd0, 32'd0,  1, 32'h8);
        set_vec(19, 1, 1, 2'd0, 32'h1,  0, 32'h1);
        set_vec(20, 1, 0, 2'd2, 32'd0,  0, 32'd0);
        set_vec(21, 1, 0, 2'd2, 32'd0,  0, 32'd0);
        set_vec(22, 1, 0, 2'd2, 32'd0,  0, 32'd0);
        set_vec(23, 1, 0, 2'd0, 32'd0,  0, 32'h0);
        set_vec(24, 1, 1, 2'd0, 32'hB,  0, RELOAD ? 32'hB : 32'h9);
        set_vec(25, 1, 1, 2'd0, 32'h0,  0, 32'h0);
        set_vec(26, 0, 1, 2'd1, 32'h1234, 0, 32'h0);
        set_vec(27, 1, 0, 2'd1, 32'd0,  0, 32'h0);
        set_vec(28, 1, 0, 2'd3, 32'd0,  0, 32'h0);
        set_vec(29, 1, 1, 2'd2, 32'hDEAD, 0, 32'h0);

        // Reset state.
        step(0, 1, 0, 2'd0, 32'd0);
        check("reset_ctrl", rdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);

        for (int i = 0; i < 30; i++) begin
            step(1, tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].d);
            check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].e_irq});
            check($sformatf("vec%0d_rdata", i), rdata, tbl[i].e_rd);
        end

        // Reset in the middle of a count.
        step(0, 1, 0, 2'd0, 32'd0);
        step(1, 1, 1, 2'd1, 32'd10);
        step(1, 1, 1, 2'd0, 32'h9);
        for (int i = 0; i < 7; i++) step(1, 1, 0, 2'd2, 32'd0);
        check("midcount_count", rdata, 32'd5);
        step(0, 1, 0, 2'd2, 32'd0);
        check("rst_count", rdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        step(1, 1, 0, 2'd0, 32'd0);
        check("rst_ctrl", rdata, 32'd0);
        step(1, 1, 0, 2'd1, 32'd0);
        check("rst_preset", rdata, 32'd0);
        step(1, 1, 0, 2'd2, 32'd0);
        check("rst_idle_count", rdata, 32'd0);

        // Clearing EN mid-count freezes COUNT.
        step(1, 1, 1, 2'd1, 32'd100);
        step(1, 1, 1, 2'd0, 32'h1);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 2'd2, 32'd0);
        check("run_count", rdata, 32'd92);
        step(1, 1, 1, 2'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 2'd2, 32'd0);
            check($sformatf("frozen_count%0d", i), rdata, 32'd91);
        end

`ifdef MIPS_TIMER_RELOAD_EN
        // Auto-reload: PRESET=3 gives a one-cycle irq every 6 cycles.
        step(0, 1, 0, 2'd0, 32'd0);
        step(1, 1, 1, 2'd1, 32'd3);
        step(1, 1, 1, 2'd0, 32'hB);
        for (int t = 1; t <= 30; t++) begin
            int u;
            step(1, 1, 0, 2'd2, 32'd0);
            check($sformatf("reload_irq_t%0d", t), {31'd0, irq},
                  (t >= 5 && (t - 5) % 6 == 0) ? 32'd1 : 32'd0);
            u = (t - 2) % 6;
            check($sformatf("reload_count_t%0d", t), rdata,
                  (t >= 2 && u <= 3) ? 32'(3 - u) : 32'd0);
        end
`endif

        // Randomized traffic against the model.
        step(0, 1, 0, 2'd0, 32'd0);
        for (int i = 0; i < 800; i++) begin
            logic        rn, s, w;
            logic [1:0]  a;
            logic [31:0] d;
            rn = ($urandom_range(0, 99) != 0);
            s  = ($urandom_range(0, 9) != 0) ? BASE_SEL : ~BASE_SEL;
            w  = ($urandom_range(0, 5) == 0);
            a  = 2'($urandom_range(0, 3));
            d  = $urandom;
            if (a == 2'd1) d = $urandom_range(0, 12);
            if (a == 2'd0) d[0] = ($urandom_range(0, 3) != 0);
            step(rn, s, w, a, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_timer.md
# mips_timer

Memory-mapped 32-bit down-counting timer on the microsystem data bus, decoded downstream of the pipeline CPU's MEM stage alongside data memory. The CPU writes a preset value and a control word. The block counts down and raises an interrupt request toward the CPU's exception logic, either once (one-shot) or periodically (auto-reload).

## Interface
- `BASE_SEL`, default 1'b1 — value of `sel` that enables bus access; an external decoder drives `sel`.
- `clk` input 1 — system clock; all state changes on the rising edge.
- `reset` input 1 — synchronous, active-low reset.
- `sel` input 1 — bus select for this device.
- `addr` input 2 — word address `[3:2]`: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- `we` input 1 — write enable, qualified by `sel`.
- `wdata` input 32 — write data.
- `rdata` output 32 — read data; combinational from `addr` and the current register values; 0 when `sel` is inactive or `addr` = 3.
- `irq` output 1 — interrupt request = `irq_flag & CTRL.IM`.

## Operation
- Registers:
  - CTRL: `[0]` EN, `[2:1]` MODE (0 = one-shot, 1 = auto-reload, 2/3 treated as 0), `[3]` IM. Bits `[31:4]` read as 0.
  - PRESET: 32-bit, read/write.
  - COUNT: 32-bit, read-only; writes ignored.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN → LOAD.
  - LOAD: COUNT ← PRESET; → CNT.
  - CNT:
    - if !EN → IDLE, COUNT held.
    - else if COUNT > 1: COUNT ← COUNT−1.
    - else if COUNT == 1: COUNT ← 0, `irq_flag` ← 1, → INT.
    - else (COUNT == 0, i.e. PRESET = 0): `irq_flag` ← 1, → INT.
  - INT: → IDLE.
    - MODE 0: EN ← 0; `irq_flag` stays 1 until cleared by a bus write.
    - MODE 1: `irq_flag` ← 0, giving a one-cycle pulse; EN stays 1, so the timer reloads.
- `irq_flag` clearing: any write to CTRL or PRESET clears it, in any state.
- Simultaneous events:
  - A bus write to CTRL takes priority over the INT-state EN clear. The written EN value wins.
  - A PRESET write during CNT does not change COUNT. The new value is used at the next LOAD.
  - Clearing EN during INT: INT completes → IDLE.
- Width: COUNT arithmetic is unsigned 32-bit and never wraps. The COUNT == 0 case exits to INT before any decrement.
- Reset (reset == 0 at an edge, in any state including mid-count):
  - CTRL, PRESET, COUNT, `irq_flag` ← 0; state ← IDLE.
  - `irq` = 0; `rdata` then reads 0 for all registers.

## Timing
- Edge E0: write CTRL EN = 1.
  - E1: LOAD (COUNT = P).
  - E2: CNT.
  - Edge 2 + max(P,1): INT, `irq_flag` = 1.
- MODE 1 period: P + 3 cycles for P ≥ 1.
  - `irq` is high for exactly 1 cycle per period when IM = 1.
- MODE 0: `irq` stays high from edge 2 + max(P,1) until the next CTRL/PRESET write.
- Register writes take effect at the edge where `sel & we`.
- Reads have zero-cycle latency; combinational.

## Configuration
- `MIPS_TIMER_RELOAD_EN` defined:
  - MODE 1 (auto-reload) is supported as described.
- Undefined:
  - The MODE field is forced to 0 on write and reads as 0.
  - All runs are one-shot.
  - The MODE 1 logic is not compiled in.

## Test plan
- Reset mid-count: PRESET = 10, EN = 1, assert reset at COUNT = 5 → next cycle CTRL/PRESET/COUNT/`rdata` = 0, `irq` = 0, state IDLE.
- One-shot: PRESET = 5, CTRL = 0x9 → `irq` rises at edge E7, stays high, EN reads 0. A subsequent write PRESET = 5 drops `irq` the next cycle.
- Auto-reload (macro on): PRESET = 3, CTRL = 0xB → `irq` 1-cycle pulses every 6 cycles; COUNT sequence 3,2,1,0 repeats.
- PRESET = 0 with CTRL = 0x9 → `irq` at E3; COUNT stays 0, no underflow to 0xFFFFFFFF.
- Masking and stop:
  - CTRL = 0x1 (IM = 0) → `irq` stays 0 while `irq_flag` is set.
  - Clearing EN mid-count with PRESET = 100 → COUNT freezes, value readable at `addr` = 2.
- Macro off: write CTRL = 0xB → reads 0x9; behaves as one-shot.
